// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative divider.
// Optional early-out behaviour is enabled by defining DIV_EARLY_OUT_EN.
package div_unit_pkg;

  localparam int unsigned REG_W  = 32;
  localparam int unsigned DREG_W = 64;

  localparam logic [REG_W-1:0] ZERO_WORD = 32'h0000_0000;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BY_ZERO = 2'd1,
    ST_ON      = 2'd2,
    ST_END     = 2'd3
  } div_state_e;

  function automatic logic [REG_W-1:0] neg_word(input logic [REG_W-1:0] v);
    return (~v) + 32'd1;
  endfunction

  // Magnitude of an operand: two's-complement negated only when signed and negative.
  function automatic logic [REG_W-1:0] magnitude(input logic [REG_W-1:0] v,
                                                 input logic            is_signed);
    return (is_signed && v[REG_W-1]) ? neg_word(v) : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage (master) and the divider (slave).
interface div_unit_if;
  import div_unit_pkg::*;

  logic              signed_div_i;
  logic [REG_W-1:0]  opdata1_i;
  logic [REG_W-1:0]  opdata2_i;
  logic              start_i;
  logic [DREG_W-1:0] result_o;
  logic              ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// 32-bit restoring divider, one quotient bit per cycle, result {remainder, quotient}.
// Define DIV_EARLY_OUT_EN to finish immediately when |dividend| < |divisor|.
module div_unit
  import div_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  div_state_e         state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [REG_W-1:0]   rem_q, rem_d;
  logic [REG_W-1:0]   quo_q, quo_d;
  logic [REG_W-1:0]   dsr_q, dsr_d;
  logic [REG_W-1:0]   op1_q, op1_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [DREG_W-1:0]  result_q, result_d;
  logic               ready_q, ready_d;

  logic [REG_W-1:0]   mag1, mag2;
  logic               is_zero_div, is_ovf, is_early;
  logic [REG_W:0]     trial;
  logic [REG_W-1:0]   rem_nx, quo_nx;
  logic [REG_W-1:0]   quo_fix, rem_fix;

  always_comb begin
    mag1        = magnitude(bus.opdata1_i, bus.signed_div_i);
    mag2        = magnitude(bus.opdata2_i, bus.signed_div_i);
    is_zero_div = (bus.opdata2_i == ZERO_WORD);
    is_ovf      = bus.signed_div_i && (bus.opdata1_i == 32'h8000_0000) &&
                  (bus.opdata2_i == 32'hFFFF_FFFF);
`ifdef DIV_EARLY_OUT_EN
    is_early    = !is_zero_div && (mag1 < mag2);
`else
    is_early    = 1'b0;
`endif
  end

  // quo_q doubles as the dividend shift register: its MSB feeds the partial remainder.
  always_comb begin
    trial = {rem_q, quo_q[REG_W-1]} - {1'b0, dsr_q};
    if (!trial[REG_W]) begin
      rem_nx = trial[REG_W-1:0];
      quo_nx = {quo_q[REG_W-2:0], 1'b1};
    end else begin
      rem_nx = {rem_q[REG_W-2:0], quo_q[REG_W-1]};
      quo_nx = {quo_q[REG_W-2:0], 1'b0};
    end
    quo_fix = neg_quo_q ? neg_word(quo_nx) : quo_nx;
    rem_fix = neg_rem_q ? neg_word(rem_nx) : rem_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 6'd0;
      rem_q     <= ZERO_WORD;
      quo_q     <= ZERO_WORD;
      dsr_q     <= ZERO_WORD;
      op1_q     <= ZERO_WORD;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= 64'h0;
      ready_q   <= DIV_RESULT_NOT_READY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      op1_q     <= op1_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i == DIV_START) begin
          if (is_zero_div) begin
            state_d = ST_BY_ZERO;
          end else if (is_ovf || is_early) begin
            state_d = ST_END;
          end else begin
            state_d = ST_ON;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BY_ZERO: begin
        state_d = (bus.start_i == DIV_STOP) ? ST_IDLE : ST_END;
      end
      ST_ON: begin
        if (bus.start_i == DIV_STOP) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 6'd31) begin
          state_d = ST_END;
        end else begin
          state_d = ST_ON;
        end
      end
      ST_END: begin
        state_d = (bus.start_i == DIV_STOP) ? ST_IDLE : ST_END;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are computed for the state being entered so they register alongside it.
  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    op1_d     = op1_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = 64'h0;
    ready_d   = DIV_RESULT_NOT_READY;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 6'd0;
        if (bus.start_i == DIV_START) begin
          op1_d     = bus.opdata1_i;
          quo_d     = mag1;
          dsr_d     = mag2;
          rem_d     = ZERO_WORD;
          neg_quo_d = bus.signed_div_i && (bus.opdata1_i[REG_W-1] ^ bus.opdata2_i[REG_W-1]);
          neg_rem_d = bus.signed_div_i && bus.opdata1_i[REG_W-1];
          if (state_d == ST_END) begin
            ready_d  = DIV_RESULT_READY;
            result_d = is_ovf ? {ZERO_WORD, 32'h8000_0000} : {bus.opdata1_i, ZERO_WORD};
          end else begin
            ready_d  = DIV_RESULT_NOT_READY;
          end
        end else begin
          op1_d = op1_q;
        end
      end
      ST_BY_ZERO: begin
        if (state_d == ST_END) begin
          ready_d  = DIV_RESULT_READY;
          result_d = {op1_q, 32'hFFFF_FFFF};
        end else begin
          ready_d  = DIV_RESULT_NOT_READY;
        end
      end
      ST_ON: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        if (state_d == ST_END) begin
          cnt_d    = 6'd0;
          ready_d  = DIV_RESULT_READY;
          result_d = {rem_fix, quo_fix};
        end else if (state_d == ST_IDLE) begin
          cnt_d = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_END: begin
        if (state_d == ST_END) begin
          ready_d  = DIV_RESULT_READY;
          result_d = result_q;
        end else begin
          ready_d  = DIV_RESULT_NOT_READY;
        end
      end
      default: begin
        cnt_d = 6'd0;
      end
    endcase
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed spec cases plus random operands
// against a plain-arithmetic model; honours DIV_EARLY_OUT_EN for latency.
module tb_div_unit;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  div_unit_if bus ();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: divide as mathematical integers, then apply the special cases.
  task automatic ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output int lat);
    longint sa, sb, ma, mb, q, r;
    logic [31:0] q32, r32;
    sa = sg ? longint'($signed(a)) : longint'(a);
    sb = sg ? longint'($signed(b)) : longint'(b);
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    if (b == 32'd0) begin
      res = {a, 32'hFFFF_FFFF};
      lat = 2;
    end else begin
      q   = sa / sb;
      r   = sa % sb;
      q32 = q[31:0];
      r32 = r[31:0];
      res = {r32, q32};
      lat = 33;
      if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) lat = 1;
`ifdef DIV_EARLY_OUT_EN
      if (ma < mb) lat = 1;
`endif
    end
  endtask

  // Full handshake: start, scramble operands after latching, wait, hold, release.
  task automatic run_op(input string tag, input logic sg, input logic [31:0] a,
                        input logic [31:0] b);
    logic [63:0] exp_res;
    int          lat;
    logic        early;
    ref_div(sg, a, b, exp_res, lat);
    bus.signed_div_i = sg;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    early            = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      step();
      if (i == 1) begin
        bus.signed_div_i = 1'($urandom_range(0, 1));
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
      end
      if (i < lat && bus.ready_o === 1'b1) early = 1'b1;
    end
    check1({tag, "_no_early_ready"}, early, 1'b0);
    check1({tag, "_ready"}, bus.ready_o, 1'b1);
    check64({tag, "_result"}, bus.result_o, exp_res);
    step();
    check1({tag, "_hold_ready"}, bus.ready_o, 1'b1);
    check64({tag, "_hold_result"}, bus.result_o, exp_res);
    bus.start_i = 1'b0;
    step();
    check1({tag, "_release_ready"}, bus.ready_o, 1'b0);
    check64({tag, "_release_result"}, bus.result_o, 64'h0);
  endtask

  initial begin
    logic        sg;
    logic [31:0] a, b;
    logic        seen;
    int          sel;

    vectors          = 0;
    miscompares      = 0;
    rst              = 1'b1;
    bus.start_i      = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    step();
    step();
    check1("reset_ready", bus.ready_o, 1'b0);
    check64("reset_result", bus.result_o, 64'h0);
    rst = 1'b0;
    step();

    run_op("udiv_100_7", 1'b0, 32'd100, 32'd7);
    run_op("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op("sdiv_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    run_op("sdiv_by_zero", 1'b1, 32'h1234_5678, 32'd0);
    run_op("udiv_by_zero", 1'b0, 32'h1234_5678, 32'd0);
    run_op("sdiv_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("udiv_3_10", 1'b0, 32'd3, 32'd10);
    run_op("udiv_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
    run_op("udiv_min_over_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);

    // Abort after 10 ON cycles, then a fresh divide must still be correct.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    seen             = 1'b0;
    for (int i = 0; i < 11; i++) begin
      step();
      if (bus.ready_o === 1'b1) seen = 1'b1;
    end
    bus.start_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.ready_o === 1'b1) seen = 1'b1;
    end
    check1("abort_no_ready", seen, 1'b0);
    run_op("after_abort", 1'b1, 32'hFFFF_FC18, 32'd7);

    // Reset in the middle of an ON sequence.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd999;
    bus.opdata2_i    = 32'd5;
    bus.start_i      = 1'b1;
    for (int i = 0; i < 6; i++) step();
    rst         = 1'b1;
    bus.start_i = 1'b0;
    step();
    check1("midrst_ready", bus.ready_o, 1'b0);
    check64("midrst_result", bus.result_o, 64'h0);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.ready_o === 1'b1) seen = 1'b1;
    end
    check1("midrst_no_ready", seen, 1'b0);
    run_op("after_rst", 1'b0, 32'd999, 32'd5);

    // Random operands with biased corner selection.
    for (int n = 0; n < 24; n++) begin
      sel = $urandom_range(0, 9);
      sg  = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      case (sel)
        0: b = 32'd0;
        1: begin sg = 1'b1; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(51, 1000)); end
        4: b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: ;
      endcase
      run_op($sformatf("rand%0d", n), sg, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameters: none; operand width SHALL be 32 bits (`RegBus`), result width 64 bits (`DoubleRegBus`).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset (`RstEnable`).
REQ-004 signed_div_i  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU).
REQ-005 opdata1_i  input  32  dividend.
REQ-006 opdata2_i  input  32  divisor.
REQ-007 start_i  input  1  `DivStart` request from execute stage; held high until ready_o is seen.
REQ-008 result_o  output  64  {remainder[63:32], quotient[31:0]}, registered.
REQ-009 ready_o  output  1  `DivResultReady` when result_o is valid, registered.

Function
REQ-010 FSM states SHALL be IDLE, BY_ZERO, ON, END.
REQ-011 IDLE: ready_o=0, result_o=0; operands and signed_div_i latched on the first cycle start_i=1.
REQ-012 IDLE, start_i=1, opdata2_i=0: go to BY_ZERO, then to END; quotient 0xFFFFFFFF, remainder = opdata1_i, for both signednesses.
REQ-013 IDLE, start_i=1, signed, opdata1_i=0x80000000, opdata2_i=0xFFFFFFFF: go directly to END with quotient 0x80000000, remainder 0.
REQ-014 Other starts: go to ON and run restoring division on operand magnitudes (two's-complement negation when signed and MSB=1), one quotient bit per cycle, 32 ON cycles.
REQ-015 Latency: start_i first sampled high in IDLE at cycle k → ready_o=1 in cycle k+33 (normal), k+2 (divide by zero), k+1 (overflow, early-out).
REQ-016 Signed fix-up at ON→END: quotient negated when operand signs differ; remainder takes the dividend's sign.
REQ-017 END: ready_o=1 and result_o held constant while start_i=1; start_i=0 → IDLE next cycle, ready_o=0, result_o=0.
REQ-018 start_i=0 during BY_ZERO or ON: abort (flush) → IDLE next cycle, no ready_o pulse, partial state discarded.
REQ-019 Operand input changes after latching SHALL NOT affect the result in progress.
REQ-020 start_i re-asserted in the cycle immediately after END→IDLE SHALL begin a new division normally.

Reset
REQ-021 rst=1 at any clock edge SHALL force IDLE, ready_o=0, result_o=0, iteration counter 0, overriding any operation in progress.
REQ-022 No output SHALL depend combinationally on rst.

Configuration
REQ-023 Macro DIV_EARLY_OUT_EN defined: on start, if |dividend| < |divisor| (divisor≠0), go IDLE→END directly with quotient 0, remainder = opdata1_i (sign preserved); ready_o in cycle k+1.
REQ-024 DIV_EARLY_OUT_EN undefined: such cases take the full ON path (REQ-014) with identical numerical results.

Structure
REQ-025 `DivStart`/`DivStop`, `DivResultReady`/`DivResultNotReady`, FSM state encodings, `ZeroWord`, `RegBus`/`DoubleRegBus` SHALL live in the shared defines.v.
REQ-026 Single module, no sub-module; the iteration datapath (33-bit trial subtract, shift) is inline.

Verification
REQ-027 Unsigned 100/7, start held → ready_o=1 at k+33, result_o={32'd2, 32'd14}; start dropped → ready_o=0, result_o=0 next cycle.
REQ-028 Signed -7/2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7/-2 → quotient 0xFFFFFFFD, remainder 1.
REQ-029 Divide by zero, opdata1_i=0x12345678, signed and unsigned → ready_o at k+2, result_o={0x12345678, 0xFFFFFFFF}.
REQ-030 Signed 0x80000000/0xFFFFFFFF → ready_o at k+1, result_o={0, 0x80000000}.
REQ-031 start_i dropped at ON cycle 10, then a new start → no ready_o pulse for the aborted op; the new op completes correctly at k'+33. rst pulsed mid-ON → IDLE, outputs 0.
REQ-032 With DIV_EARLY_OUT_EN, unsigned 3/10 → ready_o at k+1, result_o={3, 0}; without the macro, the same result at k+33.
